// File: rtl/color_frame_classifier_pkg.sv
// color_frame_classifier_pkg: shared encodings for the frame classifier.
// Holds RESULT codes, RGB332 field slices, colour limits and FSM states.
package color_frame_classifier_pkg;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_RED  = 2'b01;
   localparam logic [1:0] RES_BLUE = 2'b10;

   localparam int R_HI = 7;
   localparam int R_LO = 5;
   localparam int G_HI = 4;
   localparam int G_LO = 2;
   localparam int B_HI = 1;
   localparam int B_LO = 0;

   localparam logic [2:0] RED_R_MIN  = 3'd5;
   localparam logic [2:0] RED_G_MAX  = 3'd2;
   localparam logic [1:0] RED_B_MAX  = 2'd1;
   localparam logic [1:0] BLUE_B_MIN = 2'd2;
   localparam logic [2:0] BLUE_R_MAX = 3'd2;
   localparam logic [2:0] BLUE_G_MAX = 3'd3;

   typedef enum logic [1:0] {
      ST_WAIT_FRAME = 2'd0,
      ST_ACCUM      = 2'd1,
      ST_DECIDE     = 2'd2
   } state_t;

endpackage

// File: rtl/rgb332_color_detect.sv
// rgb332_color_detect: combinational red/blue classifier for one pixel.
// Ports: pixel (RGB332 in), is_red / is_blue (flags out, never both set).
module rgb332_color_detect
   import color_frame_classifier_pkg::*;
(
   input  logic [7:0] pixel,
   output logic       is_red,
   output logic       is_blue
);

   logic [2:0] r;
   logic [2:0] g;
   logic [1:0] b;

   assign r = pixel[R_HI:R_LO];
   assign g = pixel[G_HI:G_LO];
   assign b = pixel[B_HI:B_LO];

   // Red needs r >= 5, blue needs r <= 2, so the flags are exclusive.
   assign is_red  = (r >= RED_R_MIN)
                 && (g <= RED_G_MAX)
                 && (b <= RED_B_MAX);
   assign is_blue = (b >= BLUE_B_MIN)
                 && (r <= BLUE_R_MAX)
                 && (g <= BLUE_G_MAX);

endmodule

// File: rtl/color_frame_classifier.sv
// color_frame_classifier: counts red/blue pixels per VGA frame and
// reports a debounced dominant colour once per frame end.
// Ports: CLK, RESET_N (async low); PIXEL_IN, VGA_PIXEL_X/Y,
// VGA_VSYNC_NEG in; RESULT, RESULT_VALID, RED_COUNT, BLUE_COUNT out.
module color_frame_classifier
   import color_frame_classifier_pkg::*;
#(
   parameter int          SCREEN_WIDTH   = 176,
   parameter int          SCREEN_HEIGHT  = 144,
   parameter logic [14:0] COUNT_THRESH   = 15'd2000,
   parameter int          CONFIRM_FRAMES = 2
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [7:0]  PIXEL_IN,
   input  logic [9:0]  VGA_PIXEL_X,
   input  logic [9:0]  VGA_PIXEL_Y,
   input  logic        VGA_VSYNC_NEG,
   output logic [1:0]  RESULT,
   output logic        RESULT_VALID,
   output logic [14:0] RED_COUNT,
   output logic [14:0] BLUE_COUNT
);

   localparam logic [9:0]  W_LIM   = 10'(SCREEN_WIDTH);
   localparam logic [9:0]  H_LIM   = 10'(SCREEN_HEIGHT);
   localparam logic [14:0] CNT_MAX = 15'h7FFF;
   localparam int          CONF_W  = $clog2(CONFIRM_FRAMES + 1);
   localparam logic [CONF_W-1:0] CONF_LIM = CONF_W'(CONFIRM_FRAMES);
   localparam logic [CONF_W-1:0] CONF_ONE = CONF_W'(1);

   state_t state;
   state_t state_nxt;

   logic        vs_s1;
   logic        vs_s2;
   logic        vs_d;
   logic        frame_end;
   logic        win_d;
   logic        pix_ok;
   logic        is_red;
   logic        is_blue;
   logic [14:0] red_cnt;
   logic [14:0] blue_cnt;
   logic        red_win;
   logic        blue_win;
   logic [1:0]  raw;
   logic [1:0]  prev_raw;
   logic [CONF_W-1:0] conf;
   logic [CONF_W-1:0] conf_nxt;

   rgb332_color_detect u_detect (
      .pixel   (PIXEL_IN),
      .is_red  (is_red),
      .is_blue (is_blue)
   );

   // Window flag is delayed one cycle to line up with read data.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vs_s1 <= 1'b0;
         vs_s2 <= 1'b0;
         vs_d  <= 1'b0;
         win_d <= 1'b0;
      end else begin
         vs_s1 <= VGA_VSYNC_NEG;
         vs_s2 <= vs_s1;
         vs_d  <= vs_s2;
         win_d <= (VGA_PIXEL_X < W_LIM)
               && (VGA_PIXEL_Y < H_LIM);
      end
   end

   assign frame_end = vs_d & ~vs_s2;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_WAIT_FRAME;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      RESULT_VALID = 1'b0;
      unique case (state)
         ST_WAIT_FRAME: begin
            if (frame_end) state_nxt = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (frame_end) state_nxt = ST_DECIDE;
         end
         ST_DECIDE: begin
            state_nxt    = ST_ACCUM;
            RESULT_VALID = 1'b1;
         end
         default: state_nxt = ST_WAIT_FRAME;
      endcase
   end

   // A pixel landing on the frame-end cycle belongs to no frame.
   assign pix_ok = (state == ST_ACCUM) && win_d && !frame_end;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         red_cnt  <= '0;
         blue_cnt <= '0;
      end else if (state != ST_ACCUM) begin
         red_cnt  <= '0;
         blue_cnt <= '0;
      end else if (pix_ok) begin
         if (is_red && red_cnt != CNT_MAX)
            red_cnt <= red_cnt + 15'd1;
         if (is_blue && blue_cnt != CNT_MAX)
            blue_cnt <= blue_cnt + 15'd1;
      end
   end

   // red_win and blue_win are exclusive: each needs a strict majority.
   always_comb begin
      red_win  = (red_cnt >= COUNT_THRESH) && (red_cnt > blue_cnt);
      blue_win = (blue_cnt >= COUNT_THRESH) && (blue_cnt > red_cnt);
      raw      = RES_NONE;
      unique case (1'b1)
         red_win:  raw = RES_RED;
         blue_win: raw = RES_BLUE;
         default:  raw = RES_NONE;
      endcase
      conf_nxt = CONF_ONE;
      if (raw == prev_raw)
         conf_nxt = (conf == CONF_LIM) ? conf : conf + CONF_ONE;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         RESULT     <= RES_NONE;
         RED_COUNT  <= '0;
         BLUE_COUNT <= '0;
         prev_raw   <= RES_NONE;
         conf       <= '0;
      end else if (state == ST_DECIDE) begin
         RED_COUNT  <= red_cnt;
         BLUE_COUNT <= blue_cnt;
         prev_raw   <= raw;
         conf       <= conf_nxt;
         if (conf_nxt == CONF_LIM) RESULT <= raw;
      end
   end

endmodule
